// File: rtl/mantissa_aligner.sv
// Exponent-compare mantissa aligner for HUB floating-point addition.
// Shifts the smaller operand right by |Ex-Ey| over several cycles, STEP bits at a time.
module mantissa_aligner #(
    parameter int E    = 8,
    parameter int M    = 23,
    parameter int STEP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [E-1:0]        Ex,
    input  logic [E-1:0]        Ey,
    input  logic signed [E:0]   dif,
    input  logic                X_greater_than_Y,
    input  logic [M-1:0]        Mx,
    input  logic [M-1:0]        My,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [E-1:0]        E_out,
    output logic [M+1:0]        M_big,
    output logic [M+1:0]        M_small,
    output logic                swap
);

    localparam int W = M + 2;
    localparam logic [E:0] ONE    = 1;
    localparam logic [E:0] W_R    = W;
    localparam logic [E:0] STEP_R = STEP;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    logic [E:0]     rem;
    logic [E:0]     dif_u;
    logic [E:0]     dif_abs;
    logic [E:0]     k;
    logic [W-1:0]   ext_x;
    logic [W-1:0]   ext_y;
    logic [W-1:0]   work;

    // Extended HUB mantissa: hidden bit, stored bits, implicit LSB one.
    assign ext_x   = {|Ex, Mx, 1'b1};
    assign ext_y   = {|Ey, My, 1'b1};
    assign dif_u   = dif;
    assign dif_abs = dif_u[E] ? (~dif_u + ONE) : dif_u;
    assign k       = (rem < STEP_R) ? rem : STEP_R;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign M_small   = work;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            work  <= '0;
            E_out <= '0;
            M_big <= '0;
            swap  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        swap  <= ~X_greater_than_Y;
                        E_out <= X_greater_than_Y ? Ex : Ey;
                        M_big <= X_greater_than_Y ? ext_x : ext_y;
                        rem   <= dif_abs;
                        if (dif_abs == '0) begin
                            work  <= X_greater_than_Y ? ext_y : ext_x;
                            state <= DONE;
                        end else if (dif_abs >= W_R) begin
                            work  <= '0;
                            state <= DONE;
                        end else begin
                            work  <= X_greater_than_Y ? ext_y : ext_x;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= work >> k;
                    rem  <= rem - k;
                    if (rem == k) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_aligner.sv
// Directed table-driven bench for mantissa_aligner (E=8, M=23, STEP=4).
// Latency counts edges from the accept edge (accept edge = 1).
module tb_mantissa_aligner;

    localparam int E = 8;
    localparam int M = 23;
    localparam int W = M + 2;

    logic                clk = 0;
    logic                rst_n = 0;
    logic                in_valid = 0;
    logic                in_ready;
    logic [E-1:0]        Ex = 0;
    logic [E-1:0]        Ey = 0;
    logic signed [E:0]   dif = 0;
    logic                X_greater_than_Y = 0;
    logic [M-1:0]        Mx = 0;
    logic [M-1:0]        My = 0;
    logic                out_valid;
    logic                out_ready = 0;
    logic [E-1:0]        E_out;
    logic [W-1:0]        M_big;
    logic [W-1:0]        M_small;
    logic                swap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mantissa_aligner #(.E(E), .M(M), .STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .Ex(Ex), .Ey(Ey), .dif(dif),
        .X_greater_than_Y(X_greater_than_Y),
        .Mx(Mx), .My(My),
        .out_valid(out_valid), .out_ready(out_ready),
        .E_out(E_out), .M_big(M_big), .M_small(M_small),
        .swap(swap)
    );

    typedef struct {
        logic [E-1:0]      ex;
        logic [E-1:0]      ey;
        logic signed [E:0] d;
        logic              xg;
        logic [M-1:0]      mx;
        logic [M-1:0]      my;
        int                lat;
        logic [E-1:0]      e_exp;
        logic [W-1:0]      big_exp;
        logic [W-1:0]      small_exp;
        logic              swap_exp;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic present(input vec_t v);
        Ex = v.ex; Ey = v.ey; dif = v.d;
        X_greater_than_Y = v.xg; Mx = v.mx; My = v.my;
        in_valid = 1;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic run(input vec_t v, input int id);
        int cnt;
        string tag;
        tag = $sformatf("v%0d", id);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        present(v);
        @(posedge clk); #1;
        in_valid = 0;
        wait_valid(cnt);
        chk({tag, "_latency"}, 32'(cnt), 32'(v.lat));
        chk({tag, "_E_out"}, 32'(E_out), 32'(v.e_exp));
        chk({tag, "_M_big"}, 32'(M_big), 32'(v.big_exp));
        chk({tag, "_M_small"}, 32'(M_small), 32'(v.small_exp));
        chk({tag, "_swap"}, 32'(swap), 32'(v.swap_exp));
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [W-1:0] ext(input logic h, input logic [M-1:0] m);
        return {h, m, 1'b1};
    endfunction

    initial begin
        logic [M-1:0] a, b;
        logic [W-1:0] sb, ss;
        logic [E-1:0] se;
        logic ssw;
        int cnt;
        a = 23'h123456;
        b = 23'h654321;

        vt[0] = '{8'h80, 8'h80, 9'sd0, 1'b1, a, b, 1, 8'h80,
                  ext(1, a), ext(1, b), 1'b0};
        vt[1] = '{8'h85, 8'h80, 9'sd5, 1'b1, a, b, 3, 8'h85,
                  ext(1, a), ext(1, b) >> 5, 1'b0};
        vt[2] = '{8'h77, 8'h80, -9'sd9, 1'b0, a, b, 4, 8'h80,
                  ext(1, b), ext(1, a) >> 9, 1'b1};
        vt[3] = '{8'h9E, 8'h80, 9'sd30, 1'b1, a, b, 1, 8'h9E,
                  ext(1, a), '0, 1'b0};
        vt[4] = '{8'h03, 8'h00, 9'sd3, 1'b1, a, b, 2, 8'h03,
                  ext(1, a), ext(0, b) >> 3, 1'b0};
        vt[5] = '{8'h98, 8'h80, 9'sd24, 1'b1, a, b, 7, 8'h98,
                  ext(1, a), 25'h1, 1'b0};
        vt[6] = '{8'h99, 8'h80, 9'sd25, 1'b1, a, b, 1, 8'h99,
                  ext(1, a), '0, 1'b0};
        vt[7] = '{8'h7C, 8'h80, -9'sd4, 1'b0, a, b, 2, 8'h80,
                  ext(1, b), ext(1, a) >> 4, 1'b1};
        vt[8] = '{8'h00, 8'h00, 9'sd0, 1'b1, a, b, 1, 8'h00,
                  ext(0, a), ext(0, b), 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_E_out", 32'(E_out), 32'd0);
        chk("rst_M_big", 32'(M_big), 32'd0);
        chk("rst_M_small", 32'(M_small), 32'd0);
        chk("rst_swap", 32'(swap), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run(vt[i], i);

        // Hold in DONE with backpressure while new operands are offered
        present(vt[1]);
        @(posedge clk); #1;
        present(vt[2]);
        wait_valid(cnt);
        chk("hold_latency", 32'(cnt), 32'd3);
        sb = M_big; ss = M_small; se = E_out; ssw = swap;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_M_small", 32'(M_small), 32'(vt[1].small_exp));
            chk("hold_M_big", 32'(M_big), 32'(sb));
            chk("hold_E_out", 32'(E_out), 32'(se));
            chk("hold_swap", 32'(swap), 32'(ssw));
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_ss", 32'(ss), 32'(vt[1].small_exp));
        in_valid = 0;

        // Reset in the middle of a long shift
        present('{8'h94, 8'h80, 9'sd20, 1'b1, a, b, 6, 8'h94,
                  ext(1, a), ext(1, b) >> 20, 1'b0});
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_E_out", 32'(E_out), 32'd0);
        chk("abort_M_big", 32'(M_big), 32'd0);
        chk("abort_M_small", 32'(M_small), 32'd0);
        chk("abort_swap", 32'(swap), 32'd0);
        run(vt[1], 20);

        // Reset while a result is held drops it
        present(vt[0]);
        @(posedge clk); #1;
        in_valid = 0;
        chk("drop_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            chk("drop_no_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        run(vt[2], 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mantissa_aligner.md
MANTISSA_ALIGNER -- requirements
Module: mantissa_aligner

Interface
REQ-001 SHALL have parameter E, default 8, exponent width in bits.
REQ-002 SHALL have parameter M, default 23, stored mantissa width in bits, excluding hidden bit and HUB ILSB.
REQ-003 SHALL have parameter STEP, default 4, maximum right-shift bits per SHIFT cycle, range 1..M+2.
REQ-004 SHALL have one clock and a synchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set presented.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operand set.
REQ-007 SHALL have ports Ex and Ey, input, E bits each: unsigned exponents of X and Y.
REQ-008 SHALL have port dif, input, signed E+1 bits: Ex-Ey, zero-extended subtraction.
REQ-009 SHALL have port X_greater_than_Y, input, 1 bit: high when Ex>=Ey.
REQ-010 SHALL have ports Mx and My, input, M bits each: stored mantissas.
REQ-011 SHALL have port out_valid, output, 1 bit: aligned result available.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port E_out, output, E bits: common exponent, the larger of Ex and Ey.
REQ-014 SHALL have ports M_big and M_small, output, M+2 bits each: extended mantissa of the larger operand, and the aligned extended mantissa of the smaller operand.
REQ-015 SHALL have port swap, output, 1 bit: high when Y is the larger operand.

Function
REQ-016 SHALL form each extended mantissa as {hidden, M-bit mantissa, 1'b1}; hidden=1 when the exponent is nonzero, else 0.
REQ-017 SHALL on acceptance, set swap=~X_greater_than_Y, E_out=swap?Ey:Ex, M_big=ext(larger), working register=ext(smaller), rem=|dif| (E+1 bits, unsigned).
REQ-018 SHALL implement FSM states IDLE, SHIFT and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-019 SHALL accept an operand set only on a clk edge with in_valid&&in_ready; in_valid is ignored in SHIFT and DONE.
REQ-020 SHALL on acceptance, go to DONE when rem==0; else, when rem>=M+2, clear the working register and go to DONE; else go to SHIFT.
REQ-021 SHALL in each SHIFT cycle, logically right-shift the working register by k=min(rem,STEP) with zero fill, set rem-=k, and go to DONE when rem reaches 0.
REQ-022 SHALL raise out_valid ceil(|dif|/STEP)+1 edges after the accept edge for 0<|dif|<M+2, and 1 edge after it otherwise.
REQ-023 SHALL in DONE, hold E_out, M_big, M_small and swap stable until an edge with out_ready=1, then go to IDLE (in_ready=1 in the next cycle); no same-edge re-accept.
REQ-024 SHALL drive M_small from the working register; its value is defined only while out_valid=1.
REQ-025 SHALL not check consistency of dif against Ex/Ey; X_greater_than_Y alone selects swap.

Reset
REQ-026 SHALL when rst_n=0 at a clk edge, enter IDLE from any state, aborting any operation, and drive in_ready=1, out_valid=0, E_out=0, M_big=0, M_small=0, swap=0, rem=0.
REQ-027 SHALL drop a result held in DONE during reset, with no out_valid pulse after reset.

Verification (E=8, M=23, STEP=4)
REQ-028 SHALL cover: Ex=Ey=0x80, dif=0, X_greater_than_Y=1 -> out_valid 1 edge after accept; M_small={1,My,1} unshifted; swap=0; E_out=0x80.
REQ-029 SHALL cover: Ex=0x85, Ey=0x80, dif=5 -> 2 SHIFT cycles (4, then 1); out_valid 3 edges after accept; M_small={1,My,1}>>5; E_out=0x85.
REQ-030 SHALL cover: Ex=0x77, Ey=0x80, dif=-9, X_greater_than_Y=0 -> swap=1; M_big={1,My,1}; M_small={1,Mx,1}>>9; out_valid 4 edges after accept; E_out=0x80.
REQ-031 SHALL cover: dif=30 (>=25) -> M_small=0; out_valid 1 edge after accept; also Ey=0 -> hidden bit 0 in the shifted operand.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE with in_valid=1 -> outputs stable; in_ready=0; no new accept; IDLE one edge after out_ready=1.
REQ-033 SHALL cover: rst_n=0 for one edge during SHIFT with dif=20 -> next cycle in_ready=1, out_valid=0, all outputs 0; a new operand is accepted normally.
